// File: rtl/block_stats_pkg.sv
// Shared types and helpers for the block statistics datapath.
package block_stats_pkg;

  // Controller states; fixed 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Divide a block total by 2**log_n, optionally rounding half up.
  // Evaluated at 64 bits so the rounding bias can never wrap the total.
  function automatic logic [63:0] mean_shift(input logic [63:0] total,
                                             input int unsigned log_n,
                                             input bit round_en);
    logic [63:0] bias;
    bias = round_en ? (64'd1 << (log_n - 1)) : 64'd0;
    return (total + bias) >> log_n;
  endfunction

endpackage

// File: rtl/sample_counter.sv
// Counts accepted samples within a block; flags the last sample slot.
module sample_counter #(
  parameter int W = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Clear wins over enable; the count wraps naturally after the last slot.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == {W{1'b1}});

endmodule

// File: rtl/block_mean_stats.sv
// Block statistics: sum, mean, min and max over N streamed samples.
module block_mean_stats
  import block_stats_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N      = 32,
  parameter int ROUND  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  output logic                          busy,
  output logic                          done,
  output logic [DATA_W+$clog2(N)-1:0]   sum,
  output logic [DATA_W-1:0]             mean,
  output logic [DATA_W-1:0]             min_val,
  output logic [DATA_W-1:0]             max_val
);

  localparam int LOG_N = $clog2(N);
  localparam int ACC_W = DATA_W + LOG_N;

  state_t              state_d,   state_q;
  logic                busy_d,    busy_q;
  logic                done_d,    done_q;
  logic [ACC_W-1:0]    acc_d,     acc_q;
  logic [DATA_W-1:0]   run_min_d, run_min_q;
  logic [DATA_W-1:0]   run_max_d, run_max_q;
  logic [ACC_W-1:0]    sum_d,     sum_q;
  logic [DATA_W-1:0]   mean_d,    mean_q;
  logic [DATA_W-1:0]   min_d,     min_q;
  logic [DATA_W-1:0]   max_d,     max_q;

  logic                hs;
  logic                clr_blk;
  logic                last_slot;
  logic [ACC_W-1:0]    samp_acc;
  logic [DATA_W-1:0]   samp_min;
  logic [DATA_W-1:0]   samp_max;

  // Handshake and block-start qualifiers; start only counts outside ACC.
  always_comb begin
    hs       = in_valid && (state_q == ST_ACC);
    clr_blk  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    samp_acc = acc_q + ACC_W'(in_data);
    samp_min = (in_data < run_min_q) ? in_data : run_min_q;
    samp_max = (in_data > run_max_q) ? in_data : run_max_q;
  end

  sample_counter #(
    .W (LOG_N)
  ) u_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (clr_blk),
    .en    (hs),
    .tc    (last_slot)
  );

  // Next-state logic: controller, running statistics and result capture.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    sum_d     = sum_q;
    mean_d    = mean_q;
    min_d     = min_q;
    max_d     = max_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ACC;
          acc_d     = '0;
          run_min_d = '1;
          run_max_d = '0;
        end
      end
      ST_ACC: begin
        if (hs) begin
          acc_d     = samp_acc;
          run_min_d = samp_min;
          run_max_d = samp_max;
          // Final sample: results take the values that already include it.
          if (last_slot) begin
            state_d = ST_DONE;
            sum_d   = samp_acc;
            mean_d  = DATA_W'(mean_shift(64'(samp_acc), LOG_N, ROUND != 0));
            min_d   = samp_min;
            max_d   = samp_max;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d   = ST_ACC;
          acc_d     = '0;
          run_min_d = '1;
          run_max_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_ACC);
    done_d = (state_d == ST_DONE);
  end

  // State, status flags, running statistics and held results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_q     <= '0;
      run_min_q <= '0;
      run_max_q <= '0;
      sum_q     <= '0;
      mean_q    <= '0;
      min_q     <= '0;
      max_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      acc_q     <= acc_d;
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      sum_q     <= sum_d;
      mean_q    <= mean_d;
      min_q     <= min_d;
      max_q     <= max_d;
    end
  end

  assign in_ready = busy_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign mean     = mean_q;
  assign min_val  = min_q;
  assign max_val  = max_q;

endmodule

// File: tb/tb_block_mean_stats.sv
// Bench for block_mean_stats: truncating and rounding 32x8 instances plus 4x12 instances.
module tb_block_mean_stats;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;

  logic        a_ready, a_busy, a_done;
  logic [12:0] a_sum;
  logic [7:0]  a_mean, a_min, a_max;
  logic        b_ready, b_busy, b_done;
  logic [12:0] b_sum;
  logic [7:0]  b_mean, b_min, b_max;

  logic        s_start = 1'b0;
  logic        s_valid = 1'b0;
  logic [11:0] s_data = '0;
  logic        c_ready, c_busy, c_done;
  logic [13:0] c_sum;
  logic [11:0] c_mean, c_min, c_max;
  logic        d_ready, d_busy, d_done;
  logic [13:0] d_sum;
  logic [11:0] d_mean, d_min, d_max;

  int n_tests = 0;
  int n_fail  = 0;
  int cur[32];

  always #5 clk = ~clk;

  block_mean_stats #(.DATA_W(8), .N(32), .ROUND(0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_ready), .busy(a_busy), .done(a_done), .sum(a_sum), .mean(a_mean),
    .min_val(a_min), .max_val(a_max));

  block_mean_stats #(.DATA_W(8), .N(32), .ROUND(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_ready), .busy(b_busy), .done(b_done), .sum(b_sum), .mean(b_mean),
    .min_val(b_min), .max_val(b_max));

  block_mean_stats #(.DATA_W(12), .N(4), .ROUND(1)) dut_c (
    .clk(clk), .reset(reset), .start(s_start), .in_valid(s_valid), .in_data(s_data),
    .in_ready(c_ready), .busy(c_busy), .done(c_done), .sum(c_sum), .mean(c_mean),
    .min_val(c_min), .max_val(c_max));

  block_mean_stats #(.DATA_W(12), .N(4), .ROUND(0)) dut_d (
    .clk(clk), .reset(reset), .start(s_start), .in_valid(s_valid), .in_data(s_data),
    .in_ready(d_ready), .busy(d_busy), .done(d_done), .sum(d_sum), .mean(d_mean),
    .min_val(d_min), .max_val(d_max));

  typedef struct {
    int first;
    int step;
    int period;
    int gap;
    int poke;
    int e_sum;
    int e_mt;
    int e_mr;
    int e_min;
    int e_max;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference statistics from plain arithmetic over the sample list.
  function automatic void model(input int q[$], input bit rnd,
                                output longint s, output longint m,
                                output longint mn, output longint mx);
    longint n;
    n  = q.size();
    s  = 0;
    mn = q[0];
    mx = q[0];
    foreach (q[i]) begin
      s += q[i];
      if (q[i] < mn) mn = q[i];
      if (q[i] > mx) mx = q[i];
    end
    m = rnd ? (s + n / 2) / n : s / n;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer cur[0..n_feed-1] with random gaps; ends on the negedge after the last acceptance.
  task automatic feed(input int n_feed, input int gap, input bit poke);
    int acc = 0;
    int cyc = 0;
    int bad_ready = 0;
    int bad_done = 0;
    bit hs;
    while (acc < n_feed && cyc < 4000) begin
      in_valid = (gap == 0) || ($urandom_range(0, 99) >= gap);
      in_data  = 8'(cur[acc]);
      start    = poke && (cyc % 5 == 2);
      if (a_ready !== 1'b1 || b_ready !== 1'b1 || a_busy !== 1'b1) bad_ready++;
      hs = in_valid && a_ready;
      @(posedge clk);
      if (hs) acc++;
      @(negedge clk);
      cyc++;
      if (acc < n_feed && (a_done || b_done)) bad_done++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("accepted_count", acc, n_feed);
    chk("ready_during_acc", bad_ready, 0);
    chk("no_early_done", bad_done, 0);
  endtask

  task automatic check_results(input string tag, input longint e_sum, input longint e_mt,
                               input longint e_mr, input longint e_min, input longint e_max);
    chk({tag, "_done_a"}, a_done, 1);
    chk({tag, "_done_b"}, b_done, 1);
    chk({tag, "_sum_a"}, a_sum, e_sum);
    chk({tag, "_sum_b"}, b_sum, e_sum);
    chk({tag, "_mean_trunc"}, a_mean, e_mt);
    chk({tag, "_mean_round"}, b_mean, e_mr);
    chk({tag, "_min"}, a_min, e_min);
    chk({tag, "_max"}, a_max, e_max);
    chk({tag, "_min_b"}, b_min, e_min);
    chk({tag, "_max_b"}, b_max, e_max);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    longint ms, mt, mr, mn, mx;
    int q[$];
    int small_v[4];

    vecs[0] = '{0,   1,  32, 0,  0, 496,  15,  16,  0,   31};
    vecs[1] = '{255, 0,  1,  0,  0, 8160, 255, 255, 255, 255};
    vecs[2] = '{10,  10, 8,  50, 0, 1440, 45,  45,  10,  80};
    vecs[3] = '{0,   0,  1,  0,  0, 0,    0,   0,   0,   0};
    vecs[4] = '{0,   1,  32, 50, 1, 496,  15,  16,  0,   31};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_sum", a_sum, 0);
    chk("rst_mean", a_mean, 0);
    chk("rst_min", a_min, 0);
    chk("rst_max", a_max, 0);
    reset = 1'b1;

    // in_valid while idle is not consumed.
    in_valid = 1'b1;
    in_data  = 8'd99;
    repeat (3) @(negedge clk);
    chk("idle_ready", a_ready, 0);
    chk("idle_busy", a_busy, 0);
    in_valid = 1'b0;

    // Table-driven blocks.
    foreach (vecs[v]) begin
      for (int i = 0; i < 32; i++)
        cur[i] = vecs[v].first + vecs[v].step * (i % vecs[v].period);
      do_start();
      chk("start_busy", a_busy, 1);
      feed(32, vecs[v].gap, vecs[v].poke != 0);
      check_results($sformatf("vec%0d", v), vecs[v].e_sum, vecs[v].e_mt, vecs[v].e_mr,
                    vecs[v].e_min, vecs[v].e_max);
      @(negedge clk);
      chk("done_one_cycle", a_done, 0);
      chk("result_hold", a_sum, vecs[v].e_sum);
    end

    // start held in DONE chains straight into the next block.
    for (int i = 0; i < 32; i++) cur[i] = i;
    do_start();
    feed(32, 0, 0);
    check_results("chain_a", 496, 15, 16, 0, 31);
    for (int i = 0; i < 32; i++) cur[i] = 255;
    do_start();
    chk("chain_busy", a_busy, 1);
    chk("chain_done_low", a_done, 0);
    chk("chain_sum_held", a_sum, 496);
    chk("chain_mean_held", b_mean, 16);
    feed(32, 30, 0);
    check_results("chain_b", 8160, 255, 255, 255, 255);
    @(negedge clk);

    // Reset in the middle of a block.
    for (int i = 0; i < 32; i++) cur[i] = i;
    do_start();
    feed(17, 0, 0);
    reset = 1'b0;
    #1;
    chk("midrst_sum", a_sum, 0);
    chk("midrst_mean", a_mean, 0);
    chk("midrst_min", a_min, 0);
    chk("midrst_max", a_max, 0);
    chk("midrst_busy", a_busy, 0);
    chk("midrst_done", a_done, 0);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_no_done", a_done, 0);
    chk("midrst_needs_start", a_busy, 0);
    in_valid = 1'b0;
    for (int i = 0; i < 32; i++) cur[i] = 3;
    do_start();
    feed(32, 0, 0);
    check_results("after_rst", 96, 3, 3, 3, 3);
    @(negedge clk);

    // Randomised blocks against the reference model.
    for (int r = 0; r < 8; r++) begin
      q.delete();
      for (int i = 0; i < 32; i++) begin
        if (r % 3 == 0) cur[i] = int'($urandom_range(200, 255));
        else if (r % 3 == 1) cur[i] = int'($urandom_range(0, 40));
        else cur[i] = int'($urandom_range(0, 255));
        q.push_back(cur[i]);
      end
      model(q, 1'b0, ms, mt, mn, mx);
      model(q, 1'b1, ms, mr, mn, mx);
      do_start();
      feed(32, int'($urandom_range(0, 70)), r[0]);
      check_results($sformatf("rand%0d", r), ms, mt, mr, mn, mx);
      @(negedge clk);
    end

    // N=4, DATA_W=12 instances: rounding lands exactly on full scale.
    small_v = '{4095, 4095, 4095, 4094};
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = 12'(small_v[i]);
      chk("small_ready", c_ready, 1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("small_done", c_done, 1);
    chk("small_sum", c_sum, 16379);
    chk("small_mean_round", c_mean, 4095);
    chk("small_mean_trunc", d_mean, 4094);
    chk("small_min", c_min, 4094);
    chk("small_max", c_max, 4095);
    chk("small_sum_trunc", d_sum, 16379);
    @(negedge clk);
    chk("small_done_pulse", c_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
